// File: rtl/grid_port_arbiter.sv
// Two-requester arbiter for the playfield grid memory port A.
// Requester 0 is the game logic, requester 1 the row-clear engine.
// Arbitration is round-robin with an optional ownership lock. Grants,
// address and write data are registered. Read data comes back two
// cycles after the winning request, steered by a small tag pipeline.
module grid_port_arbiter #(
  parameter int GRID_CELLS = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       we0,
  input  logic       lock0,
  input  logic [7:0] addr0,
  input  logic [7:0] wdata0,
  output logic       gnt0,
  output logic       rvalid0,
  output logic [7:0] rdata0,
  input  logic       req1,
  input  logic       we1,
  input  logic       lock1,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata1,
  output logic       gnt1,
  output logic       rvalid1,
  output logic [7:0] rdata1,
  output logic [7:0] grid_addr,
  output logic [7:0] grid_data,
  output logic       grid_we,
  input  logic [7:0] grid_q,
  output logic       oor_err
);

  localparam logic [8:0] CELL_LIMIT = 9'(GRID_CELLS);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t     state_q, state_d, eff_state;
  logic       rr_q, rr_d;
  logic       elig0, elig1;
  logic       win0, win1, any_win;
  logic [7:0] sel_addr, sel_wdata;
  logic       sel_we, sel_oor;

  // Read tags: stage 1 aligns with the grant cycle, stage 2 with grid_q.
  logic       p1_valid, p1_id, p1_oor;
  logic       p2_valid, p2_id, p2_oor;

  // Next-state and winner selection. A lapsed lock drops the owner back
  // to IDLE within the same cycle, so that cycle arbitrates as IDLE.
  always_comb begin
    eff_state = state_q;
    if (state_q == OWN0 && !lock0) eff_state = IDLE;
    if (state_q == OWN1 && !lock1) eff_state = IDLE;

    elig0 = req0 && !gnt0;
    elig1 = req1 && !gnt1;
    case (eff_state)
      OWN0:    elig1 = 1'b0;
      OWN1:    elig0 = 1'b0;
      default: ;
    endcase

    win0    = elig0 && (!elig1 || !rr_q);
    win1    = elig1 && !win0;
    any_win = win0 || win1;

    state_d = eff_state;
    if (eff_state == IDLE) begin
      if (win0 && lock0)      state_d = OWN0;
      else if (win1 && lock1) state_d = OWN1;
    end

    rr_d = rr_q;
    if (win0)      rr_d = 1'b1;
    else if (win1) rr_d = 1'b0;

    sel_addr  = win1 ? addr1  : addr0;
    sel_wdata = win1 ? wdata1 : wdata0;
    sel_we    = win1 ? we1    : we0;
    sel_oor   = {1'b0, sel_addr} >= CELL_LIMIT;
  end

  // Owner state and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  // Registered port A drive and grant pulses; address/data hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      grid_addr <= '0;
      grid_data <= '0;
      grid_we   <= 1'b0;
      oor_err   <= 1'b0;
    end else begin
      gnt0    <= win0;
      gnt1    <= win1;
      grid_we <= 1'b0;
      oor_err <= 1'b0;
      if (any_win) begin
        grid_addr <= sel_addr;
        grid_data <= sel_wdata;
        grid_we   <= sel_we && !sel_oor;
        oor_err   <= sel_oor;
      end
    end
  end

  // Read tag pipeline; reset clears it so in-flight reads are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_valid <= 1'b0;
      p1_id    <= 1'b0;
      p1_oor   <= 1'b0;
      p2_valid <= 1'b0;
      p2_id    <= 1'b0;
      p2_oor   <= 1'b0;
    end else begin
      p1_valid <= any_win && !sel_we;
      p1_id    <= win1;
      p1_oor   <= sel_oor;
      p2_valid <= p1_valid;
      p2_id    <= p1_id;
      p2_oor   <= p1_oor;
    end
  end

  // Return steering: grid_q passes only to the tagged requester, and only in range.
  always_comb begin
    rvalid0 = p2_valid && !p2_id;
    rvalid1 = p2_valid && p2_id;
    rdata0  = '0;
    rdata1  = '0;
    if (rvalid0 && !p2_oor) rdata0 = grid_q;
    if (rvalid1 && !p2_oor) rdata1 = grid_q;
  end

endmodule

// File: doc/grid_port_arbiter.md
GRID_PORT_ARBITER -- requirements
Module: grid_port_arbiter

Interface
REQ-001 The block SHALL have one parameter: GRID_CELLS, default 200, meaning the number of valid grid cells (10x20); addresses at or above it are out of range.
REQ-002 The block SHALL have these ports, clock and reset first:
  clk         in   1  system clock; all state changes on its rising edge
  reset       in   1  asynchronous, active-low reset
  req0        in   1  requester 0 (game logic) access request
  we0         in   1  requester 0: 1 = write, 0 = read
  lock0       in   1  requester 0 ownership request
  addr0       in   8  requester 0 grid cell address
  wdata0      in   8  requester 0 write data
  gnt0        out  1  requester 0 access accepted (one-cycle pulse)
  rvalid0     out  1  requester 0 read data valid (one-cycle pulse)
  rdata0      out  8  requester 0 read data
  req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1: the same set for requester 1 (row-clear engine)
  grid_addr   out  8  grid memory port A address
  grid_data   out  8  grid memory port A write data
  grid_we     out  1  grid memory port A write enable
  grid_q      in   8  grid memory port A read data (synchronous read, 1-cycle latency)
  oor_err     out  1  out-of-range access flag (one-cycle pulse)

Function
REQ-003 The block SHALL grant at most one access per cycle; grid port A SHALL be driven only by the arbiter.
REQ-004 Eligible-request rule: reqX SHALL count as eligible in a cycle only if gntX is low in that cycle.
REQ-005 Owner state machine:
  - States: IDLE, OWN0, OWN1.
  - IDLE -> OWNX when requester X is granted with lockX high.
  - OWNX -> IDLE in any cycle where lockX is low; that cycle is then arbitrated as IDLE.
  - In OWNX, only requester X SHALL be eligible.
REQ-006 In IDLE with both requests eligible, the round-robin pointer rr SHALL pick the winner (rr=0 selects requester 0); after any grant, rr SHALL point to the non-granted requester.
REQ-007 With exactly one eligible request, that request SHALL win regardless of rr.
REQ-008 Grant timing: a request winning in cycle N SHALL produce, in cycle N+1:
  - gntX = 1;
  - grid_addr = addrX and grid_data = wdataX;
  - grid_we = weX, gated as in REQ-011.
REQ-009 Requesters SHALL hold reqX, weX, addrX and wdataX stable from assertion until they see gntX; the block relies on this.
REQ-010 Read return: for a granted read, rvalidX SHALL be 1 in cycle N+2, with rdataX = grid_q in that cycle. Outside valid cycles, rdataX SHALL be 0.
REQ-011 Out-of-range handling: a granted access with addrX >= GRID_CELLS SHALL still grant, with these rules:
  - grid_we SHALL be forced to 0;
  - a read SHALL return rdataX = 0 with rvalidX at N+2;
  - oor_err SHALL pulse 1 in cycle N+1.
REQ-012 With no grant in a cycle, the next cycle SHALL have grid_we = 0 and gnt0 = gnt1 = 0; grid_addr and grid_data SHALL hold their previous values.
REQ-013 A read pipeline tag (valid bit, requester id, oor bit) SHALL track each access so that a grant in cycle N+1 and a return in cycle N+2 from different requesters never interfere.
REQ-014 Throughput: one requester alone SHALL be granted every other cycle; two active requesters SHALL be granted in alternating cycles with no idle cycle.

Reset
REQ-015 While reset is low, the following SHALL hold asynchronously:
  - gnt0, gnt1, rvalid0, rvalid1, grid_we and oor_err SHALL be 0;
  - rdata0, rdata1, grid_addr and grid_data SHALL be 0;
  - the state SHALL be IDLE and rr SHALL be 0;
  - the pipeline tags SHALL be cleared.
REQ-016 Reset asserted mid-operation SHALL discard in-flight reads: no rvalid SHALL occur after reset deasserts unless there is a new grant.
REQ-017 The first arbitration SHALL occur on the first rising clk edge after reset deasserts.

Verification
REQ-018 Scenario: req0 write, addr0=1, wdata0=0x01, alone -> gnt0=1, grid_we=1, grid_addr=1, grid_data=0x01 in cycle N+1; later read of addr 1 -> rvalid0=1, rdata0=0x01 at N+2.
REQ-019 Scenario: req0 and req1 reads asserted together after reset -> gnt0 at N+1, gnt1 at N+2; rvalid0 at N+2, rvalid1 at N+3; no cycle with both gnts high.
REQ-020 Scenario: lock1=1 with req1 held for 3 accesses while req0 is high -> only gnt1 pulses, every other cycle; after lock1 drops, gnt0 follows within 2 cycles.
REQ-021 Scenario: req1 write to addr 200 -> gnt1=1, grid_we=0, oor_err=1 in N+1; read of addr 250 -> rdata=0 with rvalid.
REQ-022 Scenario: reset pulled low the cycle after a read grant -> all outputs 0 immediately; no rvalid after release; state is IDLE and rr=0.
